// File: rtl/ts_capture_arb_if.sv
// rtl/ts_capture_arb_if.sv - register-side read port of the timestamp capture queue
interface ts_capture_arb_if #(
    parameter int REC_W = 88
);
    logic             q_rd_en;
    logic             q_rd_valid;
    logic [REC_W-1:0] q_rd_data;

    modport master (
        output q_rd_en,
        input  q_rd_valid,
        input  q_rd_data
    );

    modport slave (
        input  q_rd_en,
        output q_rd_valid,
        output q_rd_data
    );
endinterface

// File: rtl/ts_capture_arb.sv
// rtl/ts_capture_arb.sv - N-channel RTC timestamp capture FIFOs drained by a round-robin read port
module ts_capture_arb #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 8,
    parameter int SEC_W  = 48,
    parameter int NS_W   = 30,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEC_W-1:0]        rtc_sec_in,
    input  logic [NS_W-1:0]         rtc_ns_in,
    input  logic [NUM_CH-1:0]       evt_in,
    input  logic [NUM_CH*TAG_W-1:0] evt_tag_in,
    input  logic                    q_clr,
    ts_capture_arb_if.slave         rd,
    output logic                    q_empty,
    output logic [NUM_CH-1:0]       q_ne,
    output logic [NUM_CH-1:0]       q_ovf,
    output logic [NUM_CH*CNT_W-1:0] q_drop_cnt
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int PAY_W = TAG_W + SEC_W + NS_W;
    localparam int REC_W = CH_W + PAY_W;

    logic [PAY_W-1:0]                  mem_q [NUM_CH][DEPTH];
    logic [NUM_CH-1:0][PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [NUM_CH-1:0][PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [NUM_CH-1:0]                 ovf_q, ovf_d;
    logic [NUM_CH-1:0][CNT_W-1:0]      cnt_q, cnt_d;
    logic [CH_W-1:0]                   arb_ptr_q, arb_ptr_d;
    logic                              rd_valid_q, rd_valid_d;
    logic [REC_W-1:0]                  rd_data_q, rd_data_d;

    logic [NUM_CH-1:0]                 ne;
    logic [NUM_CH-1:0]                 full;
    logic [NUM_CH-1:0]                 push;
    logic [NUM_CH-1:0]                 pop;
    logic [NUM_CH-1:0]                 drop;
    logic [NUM_CH-1:0][PAY_W-1:0]      cap_rec;
    logic [CH_W-1:0]                   grant;
    logic                              grant_vld;
    logic                              take_rd;
    logic [PAY_W-1:0]                  head;

    // Full when the wrap bits differ but the slot indices coincide.
    always_comb begin
        ne      = '0;
        full    = '0;
        cap_rec = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ne[i]      = (wr_ptr_q[i] != rd_ptr_q[i]);
            full[i]    = (wr_ptr_q[i][PTR_W-1] != rd_ptr_q[i][PTR_W-1]) &&
                         (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            cap_rec[i] = {evt_tag_in[i*TAG_W +: TAG_W], rtc_sec_in, rtc_ns_in};
        end
    end

    // Scan from farthest to nearest so the channel closest after the pointer wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            int idx;
            idx = (int'(arb_ptr_q) + k) % NUM_CH;
            if (ne[idx]) begin
                grant     = CH_W'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    assign take_rd = rd.q_rd_en && grant_vld && !q_clr;
    assign head    = mem_q[grant][rd_ptr_q[grant][AW-1:0]];

    // A pop on the same channel frees the slot this cycle, so a full FIFO still accepts the push.
    always_comb begin
        pop  = '0;
        push = '0;
        drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i]  = take_rd && (grant == CH_W'(i));
            push[i] = evt_in[i] && !q_clr && (!full[i] || pop[i]);
            drop[i] = evt_in[i] && !q_clr && full[i] && !pop[i];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (q_clr) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                ovf_d[i]    = 1'b0;
                cnt_d[i]    = '0;
            end else begin
                wr_ptr_d[i] = wr_ptr_q[i] + {{(PTR_W-1){1'b0}}, push[i]};
                rd_ptr_d[i] = rd_ptr_q[i] + {{(PTR_W-1){1'b0}}, pop[i]};
                ovf_d[i]    = ovf_q[i] | drop[i];
                if (drop[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        arb_ptr_d  = arb_ptr_q;
        rd_valid_d = take_rd;
        rd_data_d  = rd_data_q;
        if (q_clr) begin
            arb_ptr_d = CH_W'(NUM_CH - 1);
        end else if (take_rd) begin
            arb_ptr_d = grant;
            rd_data_d = {grant, head};
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i][AW-1:0]] <= cap_rec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= '0;
            cnt_q      <= '0;
            arb_ptr_q  <= CH_W'(NUM_CH - 1);
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            arb_ptr_q  <= arb_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign q_ne          = ne;
    assign q_empty       = ~|ne;
    assign q_ovf         = ovf_q;
    assign q_drop_cnt    = cnt_q;
    assign rd.q_rd_valid = rd_valid_q;
    assign rd.q_rd_data  = rd_data_q;

endmodule

// File: doc/ts_capture_arb.md
Name: ts_capture_arb

Overview:
- Parametrised N-channel timestamp capture and readout queue, the successor to the fixed single-queue-per-port timestamp path.
- Each channel latches the current RTC time plus a caller tag on an event pulse and holds it in a private FIFO.
- A round-robin arbiter drains all channels through one register-side read port.
- Sits between the RTC time bus and the register block, single clock domain; event pulses arrive already synchronised to clk.

Parameters:
- NUM_CH, 4, number of capture channels (1..16).
- DEPTH, 8, entries per channel FIFO (power of 2, >=2).
- TAG_W, 8, per-event tag width (message type / sequence bits).
- SEC_W, 48, RTC seconds width.
- NS_W, 30, RTC nanoseconds width.
- CNT_W, 8, per-channel drop counter width.
- Derived CH_W = max(1, clog2(NUM_CH)); REC_W = CH_W+TAG_W+SEC_W+NS_W.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rtc_sec_in  in  SEC_W  current RTC seconds.
- rtc_ns_in  in  NS_W  current RTC nanoseconds.
- evt_in  in  NUM_CH  per-channel single-cycle event pulse.
- evt_tag_in  in  NUM_CH*TAG_W  per-channel tag; channel i at [i*TAG_W +: TAG_W].
- q_clr  in  1  flush all FIFOs, clear overflow flags and drop counters.
- q_rd_en  in  1  pop request, one record per asserted cycle.
- q_rd_valid  out  1  q_rd_data holds a freshly popped record.
- q_rd_data  out  REC_W  {ch_id, tag, sec, ns}, MSB first.
- q_empty  out  1  all FIFOs empty.
- q_ne  out  NUM_CH  per-channel not-empty.
- q_ovf  out  NUM_CH  sticky per-channel overflow.
- q_drop_cnt  out  NUM_CH*CNT_W  per-channel saturating drop count.

Behaviour:
- Reset values:
  - All FIFOs empty; q_rd_valid=0; q_rd_data=0; q_empty=1; q_ne=0; q_ovf=0; q_drop_cnt=0.
  - Arbiter pointer=NUM_CH-1, so the first grant goes to channel 0.
- Capture:
  - When evt_in[i]=1 in cycle T, the record {i, tag_i, rtc_sec_in, rtc_ns_in} is sampled in cycle T.
  - The record is written at the T edge; q_ne[i]/q_empty reflect it in T+1.
  - Channels capture independently; any subset may fire in the same cycle.
- Overflow:
  - An event on a full FIFO with no simultaneous pop of that channel is dropped.
  - On a drop: q_ovf[i] sets and stays set until q_clr/rst; q_drop_cnt[i] increments and saturates at 2^CNT_W-1.
  - Stored entries are never overwritten.
- Readout:
  - When q_rd_en=1 and at least one FIFO is non-empty, grant the first non-empty channel after the pointer (wrapping modulo NUM_CH).
  - Pop that channel's head; register it onto q_rd_data with q_rd_valid=1 in the next cycle (latency 1).
  - Move the pointer to the granted channel.
  - q_rd_en with all FIFOs empty: no pop, q_rd_valid=0 next cycle, q_rd_data holds its previous value.
  - q_rd_valid is a one-cycle pulse per pop; q_rd_data holds until the next pop.
- Simultaneous push and pop on the same channel:
  - Both take effect; occupancy is unchanged.
  - On a full channel the push is accepted (no drop).
  - On an empty channel the pop is not served from the incoming event; that record becomes head next cycle.
- FIFO: per-channel read/write pointers of clog2(DEPTH)+1 bits; full = MSBs differ and LSBs equal; wrap is natural modulo 2*DEPTH.
- q_clr (one cycle):
  - Next cycle: pointers equal, q_ovf=0, counters=0, arbiter pointer reset.
  - q_rd_valid forced 0.
  - An event or q_rd_en in the same cycle is ignored and not counted.
- rst mid-operation: identical to the reset state on the next edge; in-flight reads are discarded.
- Time inputs are used as-is, with no internal adjustment.

Test Plan:
- Post-reset: q_empty=1, q_ne=0; pulse q_rd_en -> q_rd_valid stays 0 and q_rd_data=0.
- Single capture: rtc_sec=0x000000000005, rtc_ns=0x1000, evt_in=4'b0100, tag2=0xA5; then q_rd_en -> one cycle later q_rd_valid=1 and q_rd_data={2'd2,8'hA5,48'h5,30'h1000}; q_empty=1.
- Simultaneous events on all 4 channels, rtc_ns=100, then 4 back-to-back q_rd_en -> channel order 0,1,2,3, all with ns=100.
- Round-robin fairness: fill ch1 and ch3 with 2 entries each; 4 reads -> order 1,3,1,3.
- Overflow on ch0 (DEPTH=8): 10 events on consecutive cycles, rtc_ns=0..9 -> 8 stored (ns 0..7); q_ovf[0]=1; q_drop_cnt[0]=2; then 10 reads return ns 0..7 followed by two non-valid cycles.
- Boundaries:
  - Full ch0 with evt and q_rd_en in the same cycle -> no drop; count stays 8.
  - Drop counter: 300 drops with CNT_W=8 -> saturates at 255.
  - q_clr with a concurrent event -> empty, q_ovf=0, counter 0.
